// File: rtl/sha3_padder_if.sv
// Byte-stream input and rate-block output handshakes of sha3_padder.
// The in_empty signal exists only when SHA3_PADDER_EMPTY_EN is defined.
interface sha3_padder_if #(
  parameter int R = 576
) ();
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [R-1:0] out_block;
  logic         out_last;
`ifdef SHA3_PADDER_EMPTY_EN
  logic         in_empty;

  modport master (
    output in_valid, in_data, in_last, in_empty, out_ready,
    input  in_ready, out_valid, out_block, out_last
  );
  modport slave (
    input  in_valid, in_data, in_last, in_empty, out_ready,
    output in_ready, out_valid, out_block, out_last
  );
`else
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_block, out_last
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_block, out_last
  );
`endif
endinterface

// File: rtl/sha3_padder.sv
// SHA-3 rate-block assembler with pad10*1 / 0x06 suffix padding (byte 0 in the MSBs).
// Define SHA3_PADDER_EMPTY_EN to add in_empty for zero-length messages.
module sha3_padder #(
  parameter int D = 512,
  parameter int R = 1600 - 2 * D
) (
  input logic          clk,
  input logic          reset,
  sha3_padder_if.slave bus
);
  localparam int            NB       = R / 8;
  localparam int            IW       = $clog2(NB);
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  typedef enum logic [1:0] {FILL, EMIT, PADBLK} state_e;
  typedef logic [0:NB-1][7:0] block_t;

  state_e        state_q;
  logic [IW-1:0] idx_q;
  block_t        buf_q;
  logic          pad_pending_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          out_last_q;

  block_t        fill_d;
  block_t        pad_blk;
  logic [IW-1:0] idx_next;

  // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    idx_next = idx_q + 1'b1;
    pad_blk         = '0;
    pad_blk[0]      = 8'h60;
    pad_blk[NB-1]   = 8'h01;
    fill_d          = buf_q;
    for (int k = 0; k < NB; k++) begin
      if (IW'(k) == idx_q) begin
        fill_d[k] = bus.in_data;
      end else if (bus.in_last && IW'(k) > idx_q) begin
        fill_d[k] = 8'h00;
        if (IW'(k) == idx_next) fill_d[k][6:5] = 2'b11;
        if (k == NB - 1)        fill_d[k][0]   = 1'b1;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the block buffer is flops, not RAM, so it takes the async reset like any other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FILL;
      idx_q         <= '0;
      buf_q         <= '0;
      pad_pending_q <= 1'b0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          if (bus.in_valid && in_ready_q) begin
            buf_q <= fill_d;
            if (idx_q == LAST_IDX) begin
              // A full last block still needs a separate all-padding block.
              idx_q         <= '0;
              state_q       <= EMIT;
              in_ready_q    <= 1'b0;
              out_valid_q   <= 1'b1;
              out_last_q    <= 1'b0;
              pad_pending_q <= bus.in_last;
            end else if (bus.in_last) begin
              idx_q       <= '0;
              state_q     <= EMIT;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_last_q  <= 1'b1;
            end else begin
              idx_q <= idx_next;
            end
`ifdef SHA3_PADDER_EMPTY_EN
          end else if (bus.in_empty && !bus.in_valid && idx_q == '0 && in_ready_q) begin
            buf_q         <= pad_blk;
            state_q       <= EMIT;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b1;
            out_last_q    <= 1'b1;
            pad_pending_q <= 1'b0;
`endif
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            if (pad_pending_q) begin
              buf_q         <= pad_blk;
              pad_pending_q <= 1'b0;
              out_last_q    <= 1'b1;
              state_q       <= PADBLK;
            end else begin
              buf_q       <= '0;
              idx_q       <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= FILL;
            end
          end
        end
        PADBLK: begin
          if (bus.out_ready) begin
            buf_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_block = buf_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_sha3_padder.sv
// Randomized self-checking bench for sha3_padder against a padded-message reference model.
module tb_sha3_padder;
  localparam int D  = 512;
  localparam int R  = 1600 - 2 * D;
  localparam int NB = R / 8;

  typedef byte unsigned bq_t[$];
  typedef struct {
    logic [R-1:0] blk;
    logic         last;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  sha3_padder_if #(.R(R)) bus ();
  sha3_padder #(.D(D)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int           tests = 0;
  int           fails = 0;
  exp_t         exp_q[$];
  bq_t          msg_q;
  int           pushed = 0;
  int           ready_mode = 0;
  int           blocks_seen = 0;
  int           waited_v;
  logic         hold_valid = 1'b0;
  logic [R-1:0] hold_blk;
  logic         hold_last;
  logic [R-1:0] last_seen_blk = '0;
  logic [R-1:0] lit_abc;
  logic [R-1:0] lit;

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check_blk(input string name, input logic [R-1:0] act, input logic [R-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic finish_sim();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  // Reference: message, then 0x60, zeros, 0x01 up to the next block boundary (0x61 if one pad byte).
  function automatic int model_nblk(input int len);
    return len / NB + 1;
  endfunction

  function automatic byte unsigned padded_byte(input bq_t m, input int j);
    int           len;
    int           total;
    byte unsigned b;
    len   = m.size();
    total = model_nblk(len) * NB;
    if (j < len) return m[j];
    b = 8'h00;
    if (j == len)       b = b | 8'h60;
    if (j == total - 1) b = b | 8'h01;
    return b;
  endfunction

  function automatic logic [R-1:0] model_block(input bq_t m, input int n);
    logic [R-1:0] blk;
    for (int k = 0; k < NB; k++) blk[R-1-8*k -: 8] = padded_byte(m, n * NB + k);
    return blk;
  endfunction

  task automatic push_exp(input int n, input logic last);
    exp_t e;
    e.blk  = model_block(msg_q, n);
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input byte unsigned d, input bit last, output int waited);
    int  nb;
    bit  done;
    waited       = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    @(negedge clk);
    while (!bus.in_ready) begin
      waited++;
      if (waited > 2000) begin
        check_bit("in_ready_timeout", 1'b0, 1'b1);
        finish_sim();
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    msg_q.push_back(d);
    done = last || (msg_q.size() % NB == 0);
    if (last) begin
      nb = model_nblk(msg_q.size());
      for (int n = pushed; n < nb; n++) push_exp(n, n == nb - 1);
      msg_q.delete();
      pushed = 0;
    end else if (msg_q.size() % NB == 0) begin
      push_exp(pushed, 1'b0);
      pushed++;
    end
    if (done) check_bit("valid_latency", bus.out_valid, 1'b1);
  endtask

  task automatic send_msg(input bq_t m, input int gap_max);
    int w;
    for (int i = 0; i < m.size(); i++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) @(posedge clk);
        #1;
      end
      send_byte(m[i], i == m.size() - 1, w);
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && c < 3000) begin
      @(posedge clk);
      c++;
    end
    #1;
    check_bit("drain", exp_q.size() == 0 && !bus.out_valid, 1'b1);
  endtask

  // Output sink: out_ready changes at +2 after each edge so it never races the drivers.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Compare process: every meaningful output cycle checked against the model queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_valid = 1'b0;
      end else if (bus.out_valid) begin
        check_bit("in_ready_low_while_emitting", bus.in_ready, 1'b0);
        if (hold_valid) begin
          check_blk("block_stable", bus.out_block, hold_blk);
          check_bit("last_stable", bus.out_last, hold_last);
        end
        if (bus.out_ready) begin
          hold_valid = 1'b0;
          blocks_seen++;
          last_seen_blk = bus.out_block;
          if (exp_q.size() == 0) begin
            check_bit("unexpected_block", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check_blk("out_block", bus.out_block, e.blk);
            check_bit("out_last", bus.out_last, e.last);
          end
        end else begin
          hold_valid = 1'b1;
          hold_blk   = bus.out_block;
          hold_last  = bus.out_last;
        end
      end else begin
        hold_valid = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    check_bit("global_timeout", 1'b0, 1'b1);
    finish_sim();
  end

  initial begin
    bq_t m;
    int  b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
`ifdef SHA3_PADDER_EMPTY_EN
    bus.in_empty = 1'b0;
`endif

    // Hand-computed pins on the model itself.
    m = '{8'h61, 8'h62, 8'h63};
    lit_abc = '0;
    lit_abc[R-1 -: 32] = 32'h61626360;
    lit_abc[7:0] = 8'h01;
    check_blk("pin_abc", model_block(m, 0), lit_abc);
    check_bit("pin_abc_nblk", model_nblk(m.size()) == 1, 1'b1);
    m.delete();
    for (int k = 0; k < 71; k++) m.push_back(8'(k));
    lit = '0;
    for (int k = 0; k < 71; k++) lit[R-1-8*k -: 8] = 8'(k);
    lit[7:0] = 8'h61;
    check_blk("pin_71", model_block(m, 0), lit);
    m.push_back(8'h47);
    lit = '0;
    lit[R-1 -: 8] = 8'h60;
    lit[7:0] = 8'h01;
    check_blk("pin_72_padblk", model_block(m, 1), lit);
    check_bit("pin_72_nblk", model_nblk(m.size()) == 2, 1'b1);

    // Reset state.
    #2;
    check_bit("rst_out_valid", bus.out_valid, 1'b0);
    check_bit("rst_in_ready", bus.in_ready, 1'b0);
    check_bit("rst_out_last", bus.out_last, 1'b0);
    check_blk("rst_out_block", bus.out_block, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_bit("in_ready_before_first_edge", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    check_bit("in_ready_after_reset", bus.in_ready, 1'b1);

    // Test 1: "abc".
    ready_mode = 0;
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 0);
    drain();
    check_blk("abc_literal", last_seen_blk, lit_abc);

    // Test 2: 71 bytes, final pad byte 0x61.
    m.delete();
    for (int k = 0; k < 71; k++) m.push_back(8'(k));
    send_msg(m, 0);
    drain();

    // Test 3: 72 bytes, data block then full pad block.
    m.push_back(8'h47);
    send_msg(m, 0);
    drain();
    check_blk("padblk_literal", last_seen_blk, lit);

    // Test 4: backpressure, held byte waits for the emit to finish.
    ready_mode = 2;
    m = '{8'hde, 8'had, 8'hbe, 8'hef, 8'h01};
    send_msg(m, 0);
    fork
      send_byte(8'h55, 1'b0, waited_v);
      begin
        repeat (10) @(posedge clk);
        ready_mode = 0;
      end
    join
    check_bit("held_byte_waited", waited_v >= 10, 1'b1);
    send_byte(8'h66, 1'b1, waited_v);
    drain();

    // Test 5: reset after 30 accepted bytes.
    ready_mode = 1;
    m.delete();
    for (int k = 0; k < 30; k++) m.push_back(8'($urandom));
    for (int k = 0; k < 30; k++) send_byte(m[k], 1'b0, waited_v);
    reset = 1'b1;
    #1;
    check_bit("midrst_out_valid", bus.out_valid, 1'b0);
    check_bit("midrst_in_ready", bus.in_ready, 1'b0);
    check_bit("midrst_no_pending", exp_q.size() == 0, 1'b1);
    msg_q.delete();
    pushed = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    ready_mode = 0;
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 0);
    drain();
    check_blk("abc_after_reset", last_seen_blk, lit_abc);

    // Test 6: 145-byte message gives three blocks.
    m.delete();
    for (int k = 0; k < 145; k++) m.push_back(8'($urandom));
    check_bit("pin_145_byte1", model_block(m, 2)[R-9 -: 8] == 8'h60, 1'b1);
    b0 = blocks_seen;
    ready_mode = 1;
    send_msg(m, 0);
    drain();
    check_bit("blocks_145", blocks_seen - b0 == 3, 1'b1);

`ifdef SHA3_PADDER_EMPTY_EN
    ready_mode = 0;
    @(posedge clk);
    #1;
    bus.in_empty = 1'b1;
    push_exp(0, 1'b1);
    @(posedge clk);
    #1;
    bus.in_empty = 1'b0;
    check_bit("empty_valid", bus.out_valid, 1'b1);
    drain();
    check_blk("empty_literal", last_seen_blk, lit);
`endif

    // Randomized messages with random gaps and backpressure.
    ready_mode = 1;
    for (int t = 0; t < 20; t++) begin
      m.delete();
      for (int k = 0; k < int'($urandom_range(1, 200)); k++) m.push_back(8'($urandom));
      send_msg(m, ($urandom_range(0, 1) == 1) ? 2 : 0);
    end
    drain();
    check_bit("final_queue_empty", exp_q.size() == 0, 1'b1);
    finish_sim();
  end
endmodule

// File: doc/sha3_padder.md
Name: sha3_padder

Overview:
- Upstream feeder for the keccak core.
- Accepts a message as a byte stream with a valid/ready handshake and assembles R-bit rate blocks.
- Applies SHA-3 pad10*1 padding with the 0x06 domain suffix, in the byte encoding the core consumes.
- Presents each block on a valid/ready output; the core absorbs one block per output handshake.

Parameters:
- D, 512, digest width in bits (224/256/384/512).
- R, 1600-2*D, rate in bits. Always a multiple of 8. Block holds R/8 bytes.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data/in_last valid.
- in_ready  out  1  padder accepts a byte this cycle.
- in_data  in  8  message byte.
- in_last  in  1  in_data is the final message byte; qualified by in_valid.
- out_valid  out  1  out_block valid.
- out_ready  in  1  core consumes out_block this cycle.
- out_block  out  R  rate block. Byte k of the block sits at bits [R-1-8k : R-8-8k], so the first byte is in the MSBs.
- out_last  out  1  out_block is the final (padded) block of the message.
- in_empty  in  1  present only with SHA3_PADDER_EMPTY_EN (see below).

Behaviour:
- Clock and reset:
  - Single clock domain: clk. reset is asynchronous, active-high.
  - While reset is asserted: state=FILL, byte index=0, buffer zeroed, pad_pending=0, out_valid=0, out_last=0, out_block=0, in_ready=0.
  - in_ready rises in the first clk cycle after reset deasserts.
  - Reset mid-message discards all accumulated bytes and any pending block.
- Handshakes:
  - A transfer occurs when valid && ready are both high on a rising clk edge.
  - out_block and out_last stay stable while out_valid=1 && out_ready=0.
- Padding encoding (decided, matches the core):
  - First pad byte: 0x60.
  - Last byte of a padded block: 0x01.
  - If the first pad byte is also the last byte of the block: 0x61.
  - All other pad bytes: 0x00.
- States:
  - FILL:
    - in_ready=1, out_valid=0.
    - On an input transfer, byte goes to position idx and idx increments.
    - Block becomes full (idx was R/8-1) and in_last=0: go to EMIT, out_last=0, idx←0.
    - Block becomes full and in_last=1: go to EMIT, out_last=0, set pad_pending. A full extra pad block follows.
    - in_last=1 with idx<R/8-1: fill position idx+1 with 0x60 (or 0x61 if idx+1=R/8-1). Zero the remaining positions and put 0x01 in the last one. Go to EMIT with out_last=1.
  - EMIT:
    - out_valid=1, in_ready=0.
    - On an output transfer with pad_pending=1: load buffer with 0x60, zeros, and final 0x01. Clear pad_pending and go to PADBLK.
    - On an output transfer otherwise: clear buffer and idx, go to FILL.
  - PADBLK:
    - out_valid=1, out_last=1, in_ready=0.
    - On an output transfer: clear the buffer, go to FILL.
- Timing:
  - out_valid asserts the cycle after the byte that completes or terminates the block is accepted.
  - No combinational path from out_ready to in_ready beyond the state register.
  - Peak throughput: R/8 input cycles plus 1 emit cycle per block.
- Boundary conditions:
  - in_last on byte index 0 of a new block gives block 00..: byte0=data, byte1=0x60, ..., byte R/8-1=0x01.
  - in_valid held while in_ready=0: the byte is not consumed and must be held by the source.
  - A zero-length message cannot be expressed without the optional feature.

Optional Feature:
- Macro: SHA3_PADDER_EMPTY_EN.
- Defined:
  - Adds input in_empty.
  - in_empty=1 in FILL with idx=0 and in_valid=0 emits one block 0x60, zeros, 0x01 with out_last=1 (EMIT, pad_pending=0).
  - in_empty is ignored when idx≠0 or in_valid=1.
- Undefined: the port is absent and empty messages are unsupported.

Test Plan:
1. D=512 (R/8=72). Send 0x61,0x62,0x63 with last on 0x63, out_ready=1. Expect one block: bytes 61 62 63 60, 67×00, then 01; out_last=1; out_valid the cycle after the 0x63 accept.
2. Send 71 bytes 0x00..0x46 with last. Expect one block: bytes 00..46, final byte 0x61, out_last=1.
3. Send 72 bytes with last. Expect a full data block with out_last=0. Then a block of 60, 70×00, 01 with out_last=1. in_ready stays 0 across both.
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid. Expect out_block and out_last stable and in_ready=0. A byte held on in_data is accepted only after the emit completes.
5. Assert reset after 30 bytes are accepted. Expect out_valid=0 and in_ready=0 immediately. A new "abc" message afterwards yields exactly the test-1 block.
6. With SHA3_PADDER_EMPTY_EN, pulse in_empty in idle. Expect one block 60, 70×00, 01 with out_last=1. Without the macro, a 145-byte message yields 3 blocks with out_last only on the third, whose byte 1 is 0x60.
